// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES chunks,
// one chunk resolved per stage, with a valid/ready handshake that stalls the whole pipe.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
        end
    endgenerate

    logic              advance;
    logic [STAGES-1:0] vld_p;

    // Upper chunks of acc_p still hold operand A; lower chunks already hold finished sum bits.
    logic [WIDTH-1:0]  acc_p   [STAGES];
    logic [WIDTH-1:0]  b_p     [STAGES];
    logic              c_p     [STAGES];

    logic [WIDTH-1:0]  acc_in  [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic              c_in    [STAGES];
    logic [WIDTH-1:0]  acc_nxt [STAGES];
    logic              c_nxt   [STAGES];
    logic [CHUNK:0]    chunk_sum;

    logic              cin_msb;
    logic              v_nxt;
    logic              z_nxt;

    logic [WIDTH-1:0]  s_q;
    logic              cout_q;
    logic              v_q;
    logic              z_q;

    assign advance   = !vld_p[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p[STAGES-1];
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign Z         = z_q;

    always_comb begin
        chunk_sum = '0;
        acc_in[0] = A;
        b_in[0]   = sub ? ~B : B;
        c_in[0]   = sub ? 1'b1 : Cin;
        for (int k = 1; k < STAGES; k++) begin
            acc_in[k] = acc_p[k-1];
            b_in[k]   = b_p[k-1];
            c_in[k]   = c_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk_sum = {1'b0, acc_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                      + (CHUNK+1)'(c_in[k]);
            acc_nxt[k] = acc_in[k];
            acc_nxt[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            c_nxt[k] = chunk_sum[CHUNK];
        end
        // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
        cin_msb = acc_nxt[STAGES-1][WIDTH-1] ^ acc_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];
        v_nxt   = cin_msb ^ c_nxt[STAGES-1];
        z_nxt   = (acc_nxt[STAGES-1] == '0);
    end

    // Control and output stage: cleared by reset, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else if (advance) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            s_q    <= acc_nxt[STAGES-1];
            cout_q <= c_nxt[STAGES-1];
            v_q    <= v_nxt;
            z_q    <= z_nxt;
        end
    end

    // Inner stage data: no reset needed, validity is tracked by vld_p.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                acc_p[k] <= acc_nxt[k];
                b_p[k]   <= b_in[k];
                c_p[k]   <= c_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed 8-bit and 32-bit cases, a randomized
// handshake stream against an arithmetic reference model, stall holding and mid-stream reset.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       iv8, ir8, ci8, sb8, ov8, or8, co8, vv8, zz8;
    logic [7:0] a8, b8, s8;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, v, z;
    logic [31:0] a, b, s;

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        v;
        logic        z;
    } exp_t;

    exp_t        q[$];
    logic        held = 1'b0;
    logic [34:0] prev;

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .Cin(ci8),
        .sub(sb8), .out_valid(ov8), .out_ready(or8), .S(s8), .Cout(co8), .V(vv8), .Z(zz8)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .Cin(cin),
        .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(s), .Cout(cout), .V(v), .Z(z)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce modulo 2^32 and classify.
    function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi, input logic ci, input logic si);
        exp_t   r;
        longint ua, ub, us, sa, sb, ss;
        ua = longint'(ai);
        ub = longint'(bi);
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        us = si ? ua + ((longint'(1) << 32) - ub) : ua + ub + longint'(ci);
        ss = si ? sa - sb : sa + sb + longint'(ci);
        r.s    = us[31:0];
        r.cout = (us >= (longint'(1) << 32));
        r.v    = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        r.z    = (us[31:0] == 32'd0);
        return r;
    endfunction

    task automatic cyc(input logic iv, input logic ordy, input logic [31:0] ai, input logic [31:0] bi,
                       input logic ci, input logic si);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = ai;
        b         = bi;
        cin       = ci;
        sub       = si;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (held) chk("stall_hold", {s, cout, v, z}, prev);
        if (in_valid && in_ready) begin
            q.push_back(model(ai, bi, ci, si));
            accepted++;
        end
        if (out_valid && out_ready) begin
            chk("out_has_expect", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stream_s", s, e.s);
                chk("stream_cout", cout, e.cout);
                chk("stream_v", v, e.v);
                chk("stream_z", z, e.z);
            end
        end
        held = out_valid && !out_ready;
        prev = {s, cout, v, z};
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("drain_empty", q.size(), 0);
        cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("drain_idle", out_valid, 1'b0);
    endtask

    task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input logic si,
                        input logic [7:0] es, input logic ec, input logic ev, input logic ez, input string tag);
        @(negedge clk);
        iv8 = 1'b1; a8 = ai; b8 = bi; ci8 = ci; sb8 = si; or8 = 1'b1;
        #1;
        chk({tag, "_in_ready"}, ir8, 1'b1);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        chk({tag, "_not_yet"}, ov8, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, ov8, 1'b1);
        chk({tag, "_s"}, s8, es);
        chk({tag, "_cout"}, co8, ec);
        chk({tag, "_v"}, vv8, ev);
        chk({tag, "_z"}, zz8, ez);
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input logic [31:0] ai, input logic [31:0] bi, input logic ci, input logic si,
                         input logic [31:0] es, input logic ec, input logic ev, input logic ez, input string tag);
        int n;
        @(negedge clk);
        in_valid = 1'b1; a = ai; b = bi; cin = ci; sub = si; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_v"}, v, ev);
        chk({tag, "_z"}, z, ez);
        @(posedge clk);
        #1;
        held = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0; or8 = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags", {s, cout, v, z}, 35'd0);
        chk("rst_out_valid8", ov8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "w8_wrap");
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "w8_ovf");
        run8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, "w8_sub");

        run32(32'h0000FFFF, 32'h0, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, "w32_chunk_carry");
        run32(32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "w32_sub_ovf");

        accepted = 0;
        for (int i = 0; i < 2000 && accepted < 100; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("stream_accepted", accepted, 100);
        drain();

        repeat (8) cyc(1'b1, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("fill_count", q.size(), 4);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_first_result", s, q[0].s);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("release_back_to_back", out_valid, 1'b1);
        end
        drain();

        repeat (12) cyc(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", {s, cout, v, z}, 35'd0);
        q.delete();
        held = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run32(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h01234567, 1'b1, 1'b0, 1'b0, "after_rst");

        accepted = 0;
        for (int i = 0; i < 500 && accepted < 20; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
